// File: rtl/sat_sampler_pkg.sv
// Shared constants and types for the constraint-checker sample sequencer.
package sat_sampler_pkg;
  localparam int          LFSR_W    = 64;
  // Galois right-shift feedback mask for x^64+x^63+x^61+x^60+1
  localparam logic [63:0] LFSR_POLY = 64'hD800_0000_0000_0000;
  localparam logic [63:0] LANE_SALT = 64'h9E37_79B9_7F4A_7C15;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  function automatic logic [LFSR_W-1:0] lane_seed(input logic [LFSR_W-1:0] seed, input int idx);
    return seed ^ (64'(idx) * LANE_SALT);
  endfunction
endpackage

// File: rtl/sat_lfsr_lane.sv
// One 64-bit Galois LFSR lane; a zero load is replaced by 1 so the lane never locks up.
module sat_lfsr_lane
  import sat_sampler_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] value
);
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= 64'h1;
    end else if (load) begin
      value <= (load_val == '0) ? 64'h1 : load_val;
    end else if (step) begin
      value <= {1'b0, value[LFSR_W-1:1]} ^ (value[0] ? LFSR_POLY : '0);
    end
  end
endmodule

// File: rtl/sat_sample_sequencer.sv
// Hardware sampler: issues LFSR candidates to an external checker and queues the
// satisfying ones in an output FIFO until enough hits or the try budget runs out.
module sat_sample_sequencer
  import sat_sampler_pkg::*;
#(
  parameter int VEC_W     = 320,
  parameter int CHK_LAT   = 0,
  parameter int OUT_DEPTH = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [63:0]      seed,
  input  logic [CNT_W-1:0] num_samples,
  input  logic [CNT_W-1:0] max_tries,
  output logic [VEC_W-1:0] cand_vec,
  input  logic             chk_sat,
  output logic [VEC_W-1:0] smp_data,
  output logic             smp_valid,
  input  logic             smp_ready,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] tries,
  output logic [CNT_W-1:0] hits
);
  localparam int K  = (VEC_W + LFSR_W - 1) / LFSR_W;
  localparam int CW = $clog2(OUT_DEPTH + CHK_LAT + 2);
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  state_t             state;
  logic [CNT_W-1:0]   target, budget;
  logic               loaded;
  logic [K*LFSR_W-1:0] lanes;
  logic               start_ok, issue, push, pop, ret_vld;
  logic [VEC_W-1:0]   ret_data;
  logic [CW-1:0]      count, inflight;
  logic [PW-1:0]      rd_ptr, wr_ptr;
  logic [VEC_W-1:0]   mem [OUT_DEPTH];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  for (genvar i = 0; i < K; i++) begin : g_lane
    sat_lfsr_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (start_ok),
      .step     (issue),
      .load_val (lane_seed(seed, i)),
      .value    (lanes[i*LFSR_W +: LFSR_W])
    );
  end

  // Outputs read zero until the first run has loaded the lanes.
  assign cand_vec  = loaded ? lanes[VEC_W-1:0] : '0;
  assign busy      = (state != IDLE);
  assign smp_valid = (count != '0);
  assign smp_data  = smp_valid ? mem[rd_ptr] : '0;

  // FIFO slots plus tagged in-flight candidates never exceed OUT_DEPTH, so a push always has room.
  assign start_ok = start && !abort && (state == IDLE) && (count == '0);
  assign issue    = (state == RUN) && !abort && (hits < target) && (tries < budget)
                    && ((count + inflight) < CW'(OUT_DEPTH));
  assign push     = ret_vld && chk_sat && (hits < target) && !abort;
  assign pop      = smp_valid && smp_ready;

  if (CHK_LAT == 0) begin : g_comb
    assign ret_vld  = issue;
    assign ret_data = cand_vec;
    assign inflight = '0;
  end else begin : g_dly
    logic [CHK_LAT-1:0] vld_p;
    logic [VEC_W-1:0]   data_p [CHK_LAT];

    // stage p0 captures the issued candidate; stage p[CHK_LAT-1] lines up with chk_sat
    always_ff @(posedge clk) begin
      if (rst || abort) begin
        vld_p <= '0;
      end else begin
        vld_p[0] <= issue;
        for (int j = 1; j < CHK_LAT; j++) vld_p[j] <= vld_p[j-1];
      end
    end

    always_ff @(posedge clk) begin
      data_p[0] <= cand_vec;
      for (int j = 1; j < CHK_LAT; j++) data_p[j] <= data_p[j-1];
    end

    always_comb begin
      inflight = '0;
      for (int j = 0; j < CHK_LAT; j++) inflight = inflight + CW'(vld_p[j]);
    end

    assign ret_vld  = vld_p[CHK_LAT-1];
    assign ret_data = data_p[CHK_LAT-1];
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ret_data;
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !pop) assert (count < CW'(OUT_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      tries  <= '0;
      hits   <= '0;
      target <= '0;
      budget <= '0;
      loaded <= 1'b0;
      done   <= 1'b0;
      fail   <= 1'b0;
    end else begin
      done <= 1'b0;
      fail <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        if (issue) tries <= sat_inc(tries);
        if (push)  hits  <= sat_inc(hits);
        case (state)
          IDLE: if (start_ok) begin
            loaded <= 1'b1;
            target <= num_samples;
            budget <= max_tries;
            tries  <= '0;
            hits   <= '0;
            // Degenerate runs finish without ever leaving IDLE.
            if (num_samples == '0)    done  <= 1'b1;
            else if (max_tries == '0) fail  <= 1'b1;
            else                      state <= RUN;
          end
          RUN: if ((hits == target) || (tries == budget)) state <= DRAIN;
          DRAIN: if (inflight == '0) begin
            state <= IDLE;
            if (hits == target) done <= 1'b1;
            else                fail <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sat_sample_sequencer.sv
// Directed bench: three sequencer instances (checker latency 0, 3 and 2) with simple checker models.
module tb_sat_sample_sequencer;
  localparam logic [63:0] POLY = 64'hD800_0000_0000_0000;
  localparam logic [63:0] SALT = 64'h9E37_79B9_7F4A_7C15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // u0: VEC_W 320, CHK_LAT 0
  logic a_start = 0, a_abort = 0, a_chk = 0, a_ready = 0;
  logic [63:0] a_seed = '0;
  logic [15:0] a_ns = '0, a_mt = '0, a_tries, a_hits;
  logic [319:0] a_cand, a_data;
  logic a_valid, a_busy, a_done, a_fail;

  // u3: VEC_W 130, CHK_LAT 3, OUT_DEPTH 4
  logic b_start = 0, b_abort = 0, b_chk, b_ready = 0;
  logic [63:0] b_seed = '0;
  logic [15:0] b_ns = '0, b_mt = '0, b_tries, b_hits;
  logic [129:0] b_cand, b_data;
  logic b_valid, b_busy, b_done, b_fail;
  logic [2:0] b_pipe;

  // u2: VEC_W 130, CHK_LAT 2
  logic c_start = 0, c_abort = 0, c_chk, c_ready = 0;
  logic [63:0] c_seed = '0;
  logic [15:0] c_ns = '0, c_mt = '0, c_tries, c_hits;
  logic [129:0] c_cand, c_data;
  logic c_valid, c_busy, c_done, c_fail;
  logic [1:0] c_pipe;

  // Checker models: satisfied when candidate bit 0 is set, delayed by the checker latency.
  always @(posedge clk) begin
    if (rst) begin
      b_pipe <= '0;
      c_pipe <= '0;
    end else begin
      b_pipe <= {b_pipe[1:0], b_cand[0]};
      c_pipe <= {c_pipe[0], c_cand[0]};
    end
  end
  assign b_chk = b_pipe[2];
  assign c_chk = c_pipe[1];

  sat_sample_sequencer #(.VEC_W(320), .CHK_LAT(0), .OUT_DEPTH(8), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .seed(a_seed),
    .num_samples(a_ns), .max_tries(a_mt), .cand_vec(a_cand), .chk_sat(a_chk),
    .smp_data(a_data), .smp_valid(a_valid), .smp_ready(a_ready), .busy(a_busy),
    .done(a_done), .fail(a_fail), .tries(a_tries), .hits(a_hits));

  sat_sample_sequencer #(.VEC_W(130), .CHK_LAT(3), .OUT_DEPTH(4), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .seed(b_seed),
    .num_samples(b_ns), .max_tries(b_mt), .cand_vec(b_cand), .chk_sat(b_chk),
    .smp_data(b_data), .smp_valid(b_valid), .smp_ready(b_ready), .busy(b_busy),
    .done(b_done), .fail(b_fail), .tries(b_tries), .hits(b_hits));

  sat_sample_sequencer #(.VEC_W(130), .CHK_LAT(2), .OUT_DEPTH(8), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .start(c_start), .abort(c_abort), .seed(c_seed),
    .num_samples(c_ns), .max_tries(c_mt), .cand_vec(c_cand), .chk_sat(c_chk),
    .smp_data(c_data), .smp_valid(c_valid), .smp_ready(c_ready), .busy(c_busy),
    .done(c_done), .fail(c_fail), .tries(c_tries), .hits(c_hits));

  // Reference candidate generator: five 64-bit lanes, lane 0 in the LSBs.
  logic [63:0] m_lane [5];

  task automatic m_load(input logic [63:0] s);
    for (int i = 0; i < 5; i++) begin
      m_lane[i] = s ^ (64'(i) * SALT);
      if (m_lane[i] == 64'h0) m_lane[i] = 64'h1;
    end
  endtask

  task automatic m_step();
    for (int i = 0; i < 5; i++)
      m_lane[i] = m_lane[i][0] ? ((m_lane[i] >> 1) ^ POLY) : (m_lane[i] >> 1);
  endtask

  function automatic logic [319:0] m_vec();
    return {m_lane[4], m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", a_busy); end
    n_tests++; if ({a_done, a_fail} !== 2'b00) begin n_fail++; $display("FAIL reset_done_fail: got %b want 00", {a_done, a_fail}); end
    n_tests++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", a_valid); end
    n_tests++; if (a_cand !== '0) begin n_fail++; $display("FAIL reset_cand: got %0h want 0", a_cand); end
    n_tests++; if ({a_tries, a_hits} !== 32'h0) begin n_fail++; $display("FAIL reset_counters: got %0h want 0", {a_tries, a_hits}); end
    n_tests++; if (a_data !== '0) begin n_fail++; $display("FAIL reset_data: got %0h want 0", a_data); end
    n_tests++; if ({b_busy, c_busy, b_valid, c_valid} !== 4'b0) begin n_fail++; $display("FAIL reset_others: got %b want 0000", {b_busy, c_busy, b_valid, c_valid}); end
  endtask

  task automatic test_all_sat();
    logic [63:0] l0 [5];
    logic got_done, got_fail;
    l0[0] = 64'h0000_0000_0000_0001; l0[1] = 64'hD800_0000_0000_0000;
    l0[2] = 64'h6C00_0000_0000_0000; l0[3] = 64'h3600_0000_0000_0000;
    l0[4] = 64'h1B00_0000_0000_0000;
    a_chk = 1'b1; a_seed = 64'h0; a_ns = 16'd5; a_mt = 16'd100; a_ready = 1'b0;
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
    n_tests++; if (a_cand[63:0] !== 64'h1) begin n_fail++; $display("FAIL seed0_lane0: got %0h want 1", a_cand[63:0]); end
    n_tests++; if (a_cand[127:64] !== SALT) begin n_fail++; $display("FAIL seed0_lane1: got %0h want %0h", a_cand[127:64], SALT); end
    got_done = 0; got_fail = 0;
    for (int i = 0; i < 60 && !got_done && !got_fail; i++) begin
      @(negedge clk);
      got_done = a_done; got_fail = a_fail;
    end
    n_tests++; if ({got_done, got_fail} !== 2'b10) begin n_fail++; $display("FAIL allsat_done: got done/fail %b want 10", {got_done, got_fail}); end
    n_tests++; if (a_tries !== 16'd5) begin n_fail++; $display("FAIL allsat_tries: got %0d want 5", a_tries); end
    n_tests++; if (a_hits !== 16'd5) begin n_fail++; $display("FAIL allsat_hits: got %0d want 5", a_hits); end
    @(negedge clk);
    n_tests++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL allsat_pulse: got %0b want 0", a_done); end
    // start with samples still queued must be ignored
    a_seed = 64'hFFFF; a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
    n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL start_ignored: got busy %0b want 0", a_busy); end
    m_load(64'h0);
    for (int k = 0; k < 5; k++) begin
      n_tests++; if (a_valid !== 1'b1) begin n_fail++; $display("FAIL allsat_valid%0d: got %0b want 1", k, a_valid); end
      n_tests++; if (a_data[63:0] !== l0[k]) begin n_fail++; $display("FAIL allsat_lane0_%0d: got %0h want %0h", k, a_data[63:0], l0[k]); end
      n_tests++; if (a_data !== m_vec()) begin n_fail++; $display("FAIL allsat_data%0d: got %0h want %0h", k, a_data, m_vec()); end
      a_ready = 1'b1;
      @(negedge clk) a_ready = 1'b0;
      m_step();
    end
    n_tests++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL allsat_empty: got %0b want 0", a_valid); end
  endtask

  task automatic test_none_sat();
    logic got_done, got_fail, seen_valid;
    a_chk = 1'b0; a_seed = 64'h5; a_ns = 16'd3; a_mt = 16'd10;
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
    got_done = 0; got_fail = 0; seen_valid = 0;
    for (int i = 0; i < 60 && !got_done && !got_fail; i++) begin
      @(negedge clk);
      got_done = a_done; got_fail = a_fail; seen_valid |= a_valid;
    end
    n_tests++; if ({got_done, got_fail} !== 2'b01) begin n_fail++; $display("FAIL nonesat_fail: got done/fail %b want 01", {got_done, got_fail}); end
    n_tests++; if (a_tries !== 16'd10) begin n_fail++; $display("FAIL nonesat_tries: got %0d want 10", a_tries); end
    n_tests++; if (a_hits !== 16'd0) begin n_fail++; $display("FAIL nonesat_hits: got %0d want 0", a_hits); end
    n_tests++; if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL nonesat_valid: got %0b want 0", seen_valid); end
  endtask

  task automatic test_corners();
    a_ns = 16'd0; a_mt = 16'd10;
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
    n_tests++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL zero_samples_done: got %0b want 1", a_done); end
    n_tests++; if (a_tries !== 16'd0) begin n_fail++; $display("FAIL zero_samples_tries: got %0d want 0", a_tries); end
    @(negedge clk);
    n_tests++; if ({a_done, a_busy} !== 2'b00) begin n_fail++; $display("FAIL zero_samples_after: got %b want 00", {a_done, a_busy}); end
    a_ns = 16'd3; a_mt = 16'd0;
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
    n_tests++; if ({a_done, a_fail} !== 2'b01) begin n_fail++; $display("FAIL zero_tries_fail: got %b want 01", {a_done, a_fail}); end
    n_tests++; if (a_tries !== 16'd0) begin n_fail++; $display("FAIL zero_tries_tries: got %0d want 0", a_tries); end
  endtask

  task automatic test_repeat_seed();
    logic [319:0] run0 [3];
    logic got_done;
    a_chk = 1'b1; a_seed = 64'h0123_4567_89AB_CDEF; a_ns = 16'd3; a_mt = 16'd20;
    for (int r = 0; r < 2; r++) begin
      m_load(a_seed);
      @(negedge clk) a_start = 1'b1;
      @(negedge clk) a_start = 1'b0;
      got_done = 0;
      for (int i = 0; i < 40 && !got_done; i++) begin
        @(negedge clk);
        got_done = a_done;
      end
      n_tests++; if (got_done !== 1'b1) begin n_fail++; $display("FAIL repeat_done%0d: got %0b want 1", r, got_done); end
      for (int k = 0; k < 3; k++) begin
        n_tests++; if (a_data !== m_vec()) begin n_fail++; $display("FAIL repeat_data%0d_%0d: got %0h want %0h", r, k, a_data, m_vec()); end
        if (r == 0) run0[k] = a_data;
        else begin
          n_tests++; if (a_data !== run0[k]) begin n_fail++; $display("FAIL repeat_match%0d: got %0h want %0h", k, a_data, run0[k]); end
        end
        a_ready = 1'b1;
        @(negedge clk) a_ready = 1'b0;
        m_step();
      end
    end
  endtask

  task automatic test_backpressure();
    logic [319:0] mv;
    logic [129:0] exp0, expv;
    logic [15:0] t1;
    logic got_done;
    int idx, pops;
    b_seed = 64'h0000_0000_00C0_FFEE; b_ns = 16'd6; b_mt = 16'd200; b_ready = 1'b0;
    m_load(b_seed); idx = 0;
    while (m_lane[0][0] == 1'b0) begin m_step(); idx++; end
    mv = m_vec(); exp0 = mv[129:0];
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    repeat (60) @(negedge clk);
    n_tests++; if (b_hits !== 16'd4) begin n_fail++; $display("FAIL bp_hits_full: got %0d want 4", b_hits); end
    n_tests++; if ({b_busy, b_valid} !== 2'b11) begin n_fail++; $display("FAIL bp_busy_valid: got %b want 11", {b_busy, b_valid}); end
    n_tests++; if (b_data !== exp0) begin n_fail++; $display("FAIL bp_head: got %0h want %0h", b_data, exp0); end
    t1 = b_tries;
    repeat (10) @(negedge clk);
    n_tests++; if (b_tries !== t1) begin n_fail++; $display("FAIL bp_stall: got %0d want %0d", b_tries, t1); end
    n_tests++; if (b_data !== exp0) begin n_fail++; $display("FAIL bp_head_stable: got %0h want %0h", b_data, exp0); end
    m_load(b_seed); idx = 0; pops = 0; got_done = 0;
    b_ready = 1'b1;
    for (int i = 0; i < 300 && !(got_done && !b_valid); i++) begin
      if (b_valid) begin
        while (m_lane[0][0] == 1'b0) begin m_step(); idx++; end
        mv = m_vec(); expv = mv[129:0];
        m_step(); idx++;
        n_tests++; if (b_data !== expv) begin n_fail++; $display("FAIL bp_pop%0d: got %0h want %0h", pops, b_data, expv); end
        pops++;
      end
      @(negedge clk);
      got_done |= b_done;
    end
    b_ready = 1'b0;
    n_tests++; if (pops !== 6) begin n_fail++; $display("FAIL bp_pop_count: got %0d want 6", pops); end
    n_tests++; if (got_done !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %0b want 1", got_done); end
    n_tests++; if (b_hits !== 16'd6) begin n_fail++; $display("FAIL bp_hits: got %0d want 6", b_hits); end
    n_tests++; if (int'(b_tries) < idx || int'(b_tries) > idx + 3) begin n_fail++; $display("FAIL bp_tries: got %0d want %0d..%0d", b_tries, idx, idx + 3); end
  endtask

  task automatic test_abort();
    logic [319:0] mv;
    logic [129:0] expv;
    logic got_done, got_fail;
    c_seed = 64'h0000_0000_00AB_CDEF; c_ns = 16'd3; c_mt = 16'd50; c_ready = 1'b0;
    @(negedge clk) c_start = 1'b1;
    @(negedge clk) c_start = 1'b0;
    @(negedge clk) c_abort = 1'b1;
    @(negedge clk) c_abort = 1'b0;
    n_tests++; if ({c_busy, c_valid} !== 2'b00) begin n_fail++; $display("FAIL abort_idle: got busy/valid %b want 00", {c_busy, c_valid}); end
    n_tests++; if ({c_done, c_fail} !== 2'b00) begin n_fail++; $display("FAIL abort_no_pulse: got %b want 00", {c_done, c_fail}); end
    n_tests++; if (c_tries !== 16'd1) begin n_fail++; $display("FAIL abort_tries_hold: got %0d want 1", c_tries); end
    c_seed = 64'h0000_0000_0000_55AA; c_start = 1'b1;
    @(negedge clk) c_start = 1'b0;
    n_tests++; if (c_busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy: got %0b want 1", c_busy); end
    got_done = 0; got_fail = 0;
    for (int i = 0; i < 100 && !got_done && !got_fail; i++) begin
      @(negedge clk);
      got_done = c_done; got_fail = c_fail;
    end
    n_tests++; if ({got_done, got_fail} !== 2'b10) begin n_fail++; $display("FAIL restart_done: got done/fail %b want 10", {got_done, got_fail}); end
    m_load(c_seed);
    for (int k = 0; k < 3; k++) begin
      while (m_lane[0][0] == 1'b0) m_step();
      mv = m_vec(); expv = mv[129:0];
      m_step();
      n_tests++; if (c_data !== expv) begin n_fail++; $display("FAIL restart_data%0d: got %0h want %0h", k, c_data, expv); end
      c_ready = 1'b1;
      @(negedge clk) c_ready = 1'b0;
    end
    n_tests++; if (c_valid !== 1'b0) begin n_fail++; $display("FAIL restart_empty: got %0b want 0", c_valid); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_all_sat();
    test_none_sat();
    test_corners();
    test_repeat_seed();
    test_backpressure();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
